// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 framing, FREQUENCY clocks per bit, mid-bit sampling.
// Emits a one-cycle o_DV with the byte, or a one-cycle o_Frame_Err.
module uart_receiver #(
    parameter int FREQUENCY = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_Serial,
    output logic [7:0] o_Byte,
    output logic       o_DV,
    output logic       o_Frame_Err,
    output logic       o_Sig_Active
);

    localparam int HALF = FREQUENCY / 2;
    localparam logic [7:0] HALF_LAST = 8'(HALF - 1);
    localparam logic [7:0] BIT_LAST  = 8'(FREQUENCY - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_e;

    logic       s1_q, s1_d;
    logic       rx_q, rx_d;
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       dv_q, dv_d;
    logic       fe_q, fe_d;
    logic       active_q, active_d;

    // Two-flop synchroniser; reset to the idle-high line level.
    always_comb begin
        s1_d = i_Serial;
        rx_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b1;
            rx_q     <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            byte_q   <= 8'd0;
            dv_q     <= 1'b0;
            fe_q     <= 1'b0;
            active_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            rx_q     <= rx_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            fe_q     <= fe_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        fe_d     = 1'b0;
        active_d = active_q;

        case (state_q)
            IDLE: begin
                cnt_d    = 8'd0;
                idx_d    = 3'd0;
                active_d = 1'b0;
                if (!rx_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q < HALF_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    // A start bit that is gone by mid-bit was a glitch.
                    if (!rx_q) begin
                        state_d  = DATA;
                        active_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt_q < BIT_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d          = 8'd0;
                    shift_d[idx_q] = rx_q;
                    if (idx_q < 3'd7) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (cnt_q < BIT_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d    = 8'd0;
                    active_d = 1'b0;
                    state_d  = CLEANUP;
                    if (rx_q) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end

            CLEANUP: begin
                // A line held low after a bad stop bit must not look like a start.
                if (rx_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_Byte       = byte_q;
    assign o_DV         = dv_q;
    assign o_Frame_Err  = fe_q;
    assign o_Sig_Active = active_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage. It consumes the serial stream produced by the team's UART transmitter: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit FREQUENCY clocks long.
- It synchronises the line, validates the start bit at mid-bit, samples each data bit at mid-bit and checks the stop bit.
- Result: a one-cycle data-valid pulse with the received byte, or a framing-error pulse.

Parameters:
- FREQUENCY, 8, clocks per bit. Must be even and at least 4. HALF = FREQUENCY/2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_Serial  input  1  serial line, asynchronous to clk, idles high.
- o_Byte  output  8  last correctly received byte; held until the next good frame.
- o_DV  output  1  one-cycle pulse; o_Byte is valid in the same cycle.
- o_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- o_Sig_Active  output  1  high from start-bit acceptance through the end of the stop-bit sample.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE; bit counter = 0; index = 0; shift register = 0.
  - o_Byte=0x00, o_DV=0, o_Frame_Err=0, o_Sig_Active=0.
  - Both synchroniser flops set to 1.
  - Reset mid-frame aborts the frame with no o_DV and no o_Frame_Err.
- Synchroniser: 2 flops, s1 <= i_Serial, rx <= s1. Only rx is used by the FSM.
- Counter is 8 bits wide. Index is 3 bits wide.
- State IDLE:
  - cnt=0, idx=0, o_Sig_Active=0.
  - If rx==0: go to START.
- State START:
  - If cnt<HALF-1: cnt++.
  - Otherwise (mid start bit), cnt=0. If rx==0: go to DATA and set o_Sig_Active=1. If rx==1: treat as a glitch and return to IDLE with no output activity.
- State DATA:
  - If cnt<FREQUENCY-1: cnt++.
  - Otherwise, cnt=0 and shift[idx] <= rx.
  - If idx<7: idx++ and stay in DATA. If idx==7: idx=0 and go to STOP.
- State STOP:
  - If cnt<FREQUENCY-1: cnt++.
  - Otherwise, cnt=0 and o_Sig_Active=0.
  - If rx==1: o_Byte <= shift and o_DV=1 for one cycle.
  - If rx==0: o_Frame_Err=1 for one cycle and o_Byte is unchanged.
  - In both cases go to CLEANUP.
- State CLEANUP:
  - Waits until rx==1, then goes to IDLE.
  - Line held low (break or framing error) never re-triggers a start.
- Illegal state encodings go to IDLE.
- Latency: take edge 1 as the first rising edge at which i_Serial is sampled low.
  - Bit n (n=0..7) is captured at edge 3+HALF+(n+1)*FREQUENCY.
  - o_DV or o_Frame_Err is high in the cycle after edge 3+HALF+9*FREQUENCY.
  - For FREQUENCY=8: data bits are captured at edges 15, 23, …, 71, and o_DV follows edge 79.
- o_DV and o_Frame_Err are mutually exclusive and never high for two consecutive cycles.
- Back-to-back frames are accepted:
  - A start edge arriving while in CLEANUP (rx already 1) is handled correctly.
  - CLEANUP exits within 1 cycle of rx going high, leaving more than HALF cycles of margin before the next mid-start sample.

Test Plan:
1. Reset, then drive 0xA5 at FREQUENCY=8 (bits 0,1,0,1,0,0,1,0,1,1 at 8 clocks each) -> o_DV high for exactly 1 cycle after edge 79, o_Byte=0xA5, o_Frame_Err=0, o_Sig_Active high edges 7–79.
2. Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three o_DV pulses 80 cycles apart with o_Byte = 0x00, 0xFF, 0x3C in order.
3. Glitch: i_Serial low for 2 cycles, then high -> FSM returns to IDLE, no o_DV, no o_Frame_Err, o_Sig_Active stays 0; a following 0x55 frame is received correctly.
4. Framing error: send 0x12 with the stop bit 0, line held low 20 more cycles, then high -> one o_Frame_Err pulse, o_Byte retains its previous value, no new frame until the line returns high; a subsequent 0x81 frame yields o_DV with 0x81.
5. Assert rst_n=0 asynchronously mid-data (around edge 40 of a 0xC3 frame), release, then send 0x7E -> all outputs 0 immediately, no pulse for the aborted frame, 0x7E received correctly.
6. Loopback with the team's transmitter (same FREQUENCY, e.g. 16) over bytes 0x00–0xFF -> every o_DV byte equals the transmitted i_Byte and o_Frame_Err is never asserted.
